// File: rtl/ciclo_bus_rtc.sv
// Bus-cycle generator for the RTC multiplexed AD bus: one address phase plus one data phase per request.
// Optional RTC_AD_SYNC_EN: AD_in goes through a 2-flop synchronizer and the read pulse grows by 2 clocks.
module ciclo_bus_rtc #(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       E_Lect,
  input  logic       E_Esc,
  input  logic [7:0] Dir_L,
  input  logic [7:0] Dir_E,
  input  logic [7:0] Dato_E,
  input  logic [7:0] AD_in,
  output logic       DIR,
  output logic       DAT,
  output logic       cambio_estado,
  output logic [7:0] Dato_L,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       A_D,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       ocupado
);

  localparam int CW = $clog2(T_PULSE + T_GAP + 4) + 1;

  typedef enum logic [3:0] {
    IDLE, DIR_S, ADR, ADR_H, DATO_R, DAT_S, DATO_W, REC, FIN
  } state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_rd, w_rd_next;
  logic            r_prev_l, r_prev_e, r_pend_l, r_pend_e;
  logic            w_edge_l, w_edge_e, w_req_l, w_req_e, w_last, w_fin;
  logic [7:0]      w_ad_cap;

  logic            r_dir, r_dat, r_cambio, r_oe, r_a_d, r_cs_n, r_rd_n, r_wr_n, r_ocupado;
  logic [7:0]      r_dato_l, r_ad_out;
  logic            w_dir, w_dat, w_cambio, w_oe, w_a_d, w_cs_n, w_rd_n, w_wr_n, w_ocupado;
  logic [7:0]      w_ad_out;

`ifdef RTC_AD_SYNC_EN
  localparam int T_RD = T_PULSE + 2;
  logic [7:0] r_ad_s1, r_ad_s2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ad_s1 <= '0;
      r_ad_s2 <= '0;
    end else begin
      r_ad_s1 <= AD_in;
      r_ad_s2 <= r_ad_s1;
    end
  end
  assign w_ad_cap = r_ad_s2;
`else
  localparam int T_RD = T_PULSE;
  assign w_ad_cap = AD_in;
`endif

  assign w_edge_l = E_Lect & ~r_prev_l;
  assign w_edge_e = E_Esc & ~r_prev_e;
  assign w_req_l  = r_pend_l | w_edge_l;
  assign w_req_e  = r_pend_e | w_edge_e;
  assign w_fin    = (r_state == FIN);

  always_comb begin
    w_last = 1'b1;
    case (r_state)
      ADR:          w_last = (r_cnt == CW'(T_PULSE - 1));
      ADR_H, REC:   w_last = (r_cnt == CW'(T_GAP - 1));
      DATO_R:       w_last = (r_cnt == CW'(T_RD - 1));
      DATO_W:       w_last = (r_cnt == CW'(T_PULSE - 1));
      default:      w_last = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_next    = r_rd;
    case (r_state)
      IDLE: begin
        // Read wins arbitration; a losing write stays pending
        if (w_req_l) begin
          w_state_next = DIR_S;
          w_rd_next    = 1'b1;
        end else if (w_req_e) begin
          w_state_next = DIR_S;
          w_rd_next    = 1'b0;
        end
      end
      DIR_S:  w_state_next = ADR;
      ADR:    if (w_last) w_state_next = ADR_H;
      ADR_H:  if (w_last) w_state_next = r_rd ? DATO_R : DAT_S;
      DATO_R: if (w_last) w_state_next = DAT_S;
      DAT_S:  w_state_next = r_rd ? REC : DATO_W;
      DATO_W: if (w_last) w_state_next = REC;
      REC:    if (w_last) w_state_next = FIN;
      FIN:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    w_cnt_next = (w_state_next != r_state || w_state_next == IDLE) ? '0 : r_cnt + 1'b1;
  end

  // Output values are decoded from the next state so the registered outputs line up with the state.
  always_comb begin
    w_dir     = 1'b0;
    w_dat     = 1'b0;
    w_cambio  = 1'b0;
    w_oe      = 1'b0;
    w_a_d     = 1'b1;
    w_cs_n    = 1'b1;
    w_rd_n    = 1'b1;
    w_wr_n    = 1'b1;
    w_ad_out  = r_ad_out;
    w_ocupado = (w_state_next != IDLE);
    case (w_state_next)
      DIR_S: w_dir = 1'b1;
      ADR: begin
        w_a_d    = 1'b0;
        w_oe     = 1'b1;
        w_ad_out = w_rd_next ? Dir_L : Dir_E;
        w_cs_n   = 1'b0;
        w_wr_n   = 1'b0;
      end
      ADR_H: w_oe = 1'b1;
      DATO_R: begin
        w_cs_n = 1'b0;
        w_rd_n = 1'b0;
      end
      DAT_S: w_dat = 1'b1;
      DATO_W: begin
        w_oe     = 1'b1;
        w_ad_out = Dato_E;
        w_cs_n   = 1'b0;
        w_wr_n   = 1'b0;
      end
      FIN: w_cambio = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rd      <= 1'b0;
      r_prev_l  <= 1'b0;
      r_prev_e  <= 1'b0;
      r_pend_l  <= 1'b0;
      r_pend_e  <= 1'b0;
      r_dir     <= 1'b0;
      r_dat     <= 1'b0;
      r_cambio  <= 1'b0;
      r_oe      <= 1'b0;
      r_a_d     <= 1'b1;
      r_cs_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_ocupado <= 1'b0;
      r_ad_out  <= '0;
      r_dato_l  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rd      <= w_rd_next;
      r_prev_l  <= E_Lect;
      r_prev_e  <= E_Esc;
      r_pend_l  <= w_edge_l | (r_pend_l & ~(w_fin & r_rd));
      r_pend_e  <= w_edge_e | (r_pend_e & ~(w_fin & ~r_rd));
      r_dir     <= w_dir;
      r_dat     <= w_dat;
      r_cambio  <= w_cambio;
      r_oe      <= w_oe;
      r_a_d     <= w_a_d;
      r_cs_n    <= w_cs_n;
      r_rd_n    <= w_rd_n;
      r_wr_n    <= w_wr_n;
      r_ocupado <= w_ocupado;
      r_ad_out  <= w_ad_out;
      if (r_state == DATO_R && w_last)
        r_dato_l <= w_ad_cap;
    end
  end

  assign DIR           = r_dir;
  assign DAT           = r_dat;
  assign cambio_estado = r_cambio;
  assign Dato_L        = r_dato_l;
  assign AD_out        = r_ad_out;
  assign AD_oe         = r_oe;
  assign A_D           = r_a_d;
  assign CS_n          = r_cs_n;
  assign RD_n          = r_rd_n;
  assign WR_n          = r_wr_n;
  assign ocupado       = r_ocupado;

endmodule

// File: tb/tb_ciclo_bus_rtc.sv
// Scoreboard bench for ciclo_bus_rtc: stimulus queues expected transactions, a bus monitor checks them.
module tb_ciclo_bus_rtc;
  localparam int TP  = 4;
  localparam int TG  = 2;
  localparam int LAT = 2 + 2*TP + 2*TG + 1;
`ifdef RTC_AD_SYNC_EN
  localparam int RS = 2;
`else
  localparam int RS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       E_Lect = 1'b0, E_Esc = 1'b0;
  logic [7:0] Dir_L = '0, Dir_E = '0, Dato_E = '0, rtc_byte = '0;
  logic [7:0] AD_in;
  logic       DIR, DAT, cambio_estado, AD_oe, A_D, CS_n, RD_n, WR_n, ocupado;
  logic [7:0] Dato_L, AD_out;

  // The RTC drives its byte only while RD_n is low; otherwise the pads show the complement.
  assign AD_in = RD_n ? ~rtc_byte : rtc_byte;

  ciclo_bus_rtc #(.T_PULSE(TP), .T_GAP(TG)) dut (
    .clk(clk), .reset(reset), .E_Lect(E_Lect), .E_Esc(E_Esc),
    .Dir_L(Dir_L), .Dir_E(Dir_E), .Dato_E(Dato_E), .AD_in(AD_in),
    .DIR(DIR), .DAT(DAT), .cambio_estado(cambio_estado), .Dato_L(Dato_L),
    .AD_out(AD_out), .AD_oe(AD_oe), .A_D(A_D), .CS_n(CS_n), .RD_n(RD_n),
    .WR_n(WR_n), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_rd;
    logic [7:0] addr;
    logic [7:0] data;
    int         fin_cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_CS_n"}, CS_n, 1);
    chk({tag, "_RD_n"}, RD_n, 1);
    chk({tag, "_WR_n"}, WR_n, 1);
    chk({tag, "_A_D"}, A_D, 1);
    chk({tag, "_AD_oe"}, AD_oe, 0);
    chk({tag, "_AD_out"}, AD_out, 0);
    chk({tag, "_Dato_L"}, Dato_L, 0);
    chk({tag, "_strobes"}, {DIR, DAT, cambio_estado}, 0);
    chk({tag, "_ocupado"}, ocupado, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus monitor: accumulates what one transaction looked like, judged when cambio_estado appears.
  initial begin
    int a_cnt, r_cnt, w_cnt, dir_cnt, dat_cnt;
    logic [7:0] a_val, w_val, l_at_dat;
    bit saw_rd, dat_early, a_bad;
    exp_t e;
    a_cnt = 0; r_cnt = 0; w_cnt = 0; dir_cnt = 0; dat_cnt = 0;
    a_val = '0; w_val = '0; l_at_dat = '0; saw_rd = 0; dat_early = 0; a_bad = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        a_cnt = 0; r_cnt = 0; w_cnt = 0; dir_cnt = 0; dat_cnt = 0;
        saw_rd = 0; dat_early = 0; a_bad = 0;
      end else begin
        chk("no_contention", int'(!CS_n && AD_oe && !RD_n), 0);
        if (DIR) dir_cnt++;
        if (!CS_n && !A_D) begin a_cnt++; a_val = AD_out; if (!AD_oe) a_bad = 1; end
        if (!CS_n && A_D && !RD_n) begin r_cnt++; saw_rd = 1; end
        if (!CS_n && A_D && !WR_n) begin w_cnt++; w_val = AD_out; if (!AD_oe) a_bad = 1; end
        if (DAT) begin dat_cnt++; dat_early = (r_cnt == 0 && w_cnt == 0); l_at_dat = Dato_L; end
        if (cambio_estado) begin
          if (q.size() == 0) begin
            chk("unexpected_cambio_estado", 1, 0);
          end else begin
            e = q.pop_front();
            $display("txn %s addr=%02h data=%02h fin@%0d", e.is_rd ? "RD" : "WR", e.addr, e.data, cyc);
            chk("kind_is_read", saw_rd, e.is_rd);
            chk("addr_value", a_val, e.addr);
            chk("addr_cycles", a_cnt, TP);
            chk("drive_oe", a_bad, 0);
            chk("dir_pulses", dir_cnt, 1);
            chk("dat_pulses", dat_cnt, 1);
            chk("dat_before_data", dat_early, !e.is_rd);
            chk("fin_cycle", cyc, e.fin_cyc);
            if (e.is_rd) begin
              chk("rd_cycles", r_cnt, TP + RS);
              chk("dato_l_at_dat", l_at_dat, e.data);
              chk("wr_data_cycles", w_cnt, 0);
            end else begin
              chk("wr_data_cycles", w_cnt, TP);
              chk("wr_data", w_val, e.data);
              chk("rd_cycles", r_cnt, 0);
            end
          end
          a_cnt = 0; r_cnt = 0; w_cnt = 0; dir_cnt = 0; dat_cnt = 0;
          saw_rd = 0; dat_early = 0; a_bad = 0;
        end
      end
    end
  end

  // mode 0 = read, 1 = write, 2 = both requests in the same cycle
  task automatic run(input int mode, input logic [7:0] ra, input logic [7:0] rd,
                     input logic [7:0] wa, input logic [7:0] wd);
    exp_t e;
    int   f;
    @(posedge clk); #1;
    Dir_L = ra; rtc_byte = rd; Dir_E = wa; Dato_E = wd;
    if (mode == 0 || mode == 2) begin
      E_Lect = 1'b1;
      f = cyc + LAT + RS;
      e = '{1'b1, ra, rd, f};
      q.push_back(e);
    end
    if (mode == 1) begin
      E_Esc = 1'b1;
      e = '{1'b0, wa, wd, cyc + LAT};
      q.push_back(e);
    end
    if (mode == 2) begin
      E_Esc = 1'b1;
      e = '{1'b0, wa, wd, f + 1 + LAT};
      q.push_back(e);
    end
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    chk("timeout_pending", q.size(), 0);
    q.delete();
    // Requests stay high past FIN: no new transaction may start
    repeat (4) @(posedge clk);
    #1;
    chk("idle_with_level_high", ocupado, 0);
    E_Lect = 1'b0; E_Esc = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("in_reset");
    reset = 1'b0;

    // Abort a read in the middle of its address phase
    @(posedge clk); #1;
    Dir_L = 8'h21; E_Lect = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_abort_busy", {ocupado, CS_n, A_D}, 3'b100);
    #2;
    reset = 1'b1; E_Lect = 1'b0;
    #1;
    chk_reset_vals("async_abort");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_after_abort", ocupado, 0);

    run(0, 8'h21, 8'h45, 8'h00, 8'h00);
    run(1, 8'h00, 8'h00, 8'h22, 8'h30);
    run(2, 8'h5C, 8'hA3, 8'h7E, 8'h81);
    run(0, 8'h10, 8'h99, 8'h00, 8'h00);
    for (int n = 0; n < 24; n++)
      run($urandom_range(0, 2), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
